mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_pkg.sv | 14 +
 rtl/mux2to1.sv | 13 +
 rtl/mux_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared types for the two-requester mux arbiter: FSM state encoding and
// mux select encoding.
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer. SEL_A passes a and SEL_B passes b.
module mux2to1
    import mux_arbiter_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter with a bounded hold time, driving a registered
// per-bit mux data path.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] ain,
    input  logic [DATA_W-1:0] bin,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              select,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic [7:0]        switch_cnt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t              state_r;
    state_t              next_s;
    state_t              last_r;
    logic [7:0]          hold_r;
    logic                gnt_a_r;
    logic                gnt_b_r;
    logic                select_r;
    logic                sel_next_s;
    logic [DATA_W-1:0]   out_r;
    logic                out_valid_r;
    logic [7:0]          switch_cnt_r;
    logic [DATA_W-1:0]   mux_s;
    logic                enter_s;
    logic                load_s;

    // Next-state and next-select decode
    always_comb begin
        next_s     = state_r;
        sel_next_s = select_r;
        case (state_r)
            IDLE: begin
                if (req_a && req_b) begin
                    if (last_r == OWN_A) begin
                        next_s = OWN_B;
                    end else begin
                        next_s = OWN_A;
                    end
                end else if (req_a) begin
                    next_s = OWN_A;
                end else if (req_b) begin
                    next_s = OWN_B;
                end else begin
                    next_s = IDLE;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    next_s = req_b ? OWN_B : IDLE;
                end else if (req_b && (hold_r == HOLD_LAST)) begin
                    next_s = OWN_B;
                end else begin
                    next_s = OWN_A;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    next_s = req_a ? OWN_A : IDLE;
                end else if (req_a && (hold_r == HOLD_LAST)) begin
                    next_s = OWN_A;
                end else begin
                    next_s = OWN_B;
                end
            end
            default: next_s = IDLE;
        endcase
        case (next_s)
            OWN_A:   sel_next_s = SEL_A;
            OWN_B:   sel_next_s = SEL_B;
            default: sel_next_s = select_r;
        endcase
    end

    assign enter_s = (next_s != state_r) && (next_s != IDLE);
    assign load_s  = (gnt_a_r && req_a) || (gnt_b_r && req_b);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            mux2to1 u_mux (
                .a   (ain[gi]),
                .b   (bin[gi]),
                .sel (select_r),
                .y   (mux_s[gi])
            );
        end
    endgenerate

    // State, grant, select, counters and data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            last_r       <= OWN_B;
            hold_r       <= 8'd0;
            gnt_a_r      <= 1'b0;
            gnt_b_r      <= 1'b0;
            select_r     <= SEL_A;
            out_r        <= '0;
            out_valid_r  <= 1'b0;
            switch_cnt_r <= 8'd0;
        end else begin
            state_r  <= next_s;
            gnt_a_r  <= (next_s == OWN_A);
            gnt_b_r  <= (next_s == OWN_B);
            select_r <= sel_next_s;
            if (enter_s) begin
                hold_r       <= 8'd0;
                last_r       <= next_s;
                switch_cnt_r <= switch_cnt_r + 8'd1;
            end else if (hold_r != HOLD_LAST) begin
                // Saturate so a late-arriving competitor still hits the limit
                hold_r <= hold_r + 8'd1;
            end else begin
                hold_r <= hold_r;
            end
            if (load_s) begin
                out_r <= mux_s;
            end else begin
                out_r <= out_r;
            end
            out_valid_r <= load_s;
        end
    end

    assign gnt_a      = gnt_a_r;
    assign gnt_b      = gnt_b_r;
    assign select     = select_r;
    assign out        = out_r;
    assign out_valid  = out_valid_r;
    assign switch_cnt = switch_cnt_r;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter (DATA_W=8, MAX_HOLD=4).
module tb_mux_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_a;
    logic       req_b;
    logic [7:0] ain;
    logic [7:0] bin;
    logic       gnt_a;
    logic       gnt_b;
    logic       select;
    logic [7:0] out;
    logic       out_valid;
    logic [7:0] switch_cnt;

    int checks   = 0;
    int failures = 0;
    logic overlap;

    mux_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_a      (req_a),
        .req_b      (req_b),
        .ain        (ain),
        .bin        (bin),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .select     (select),
        .out        (out),
        .out_valid  (out_valid),
        .switch_cnt (switch_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req_a = 1'b1; req_b = 1'b1; ain = 8'h11; bin = 8'h22;
        overlap = 1'b0;

        // Reset dominates requests
        tick(); tick();
        chk("rst_gnt_a",  32'(gnt_a), 32'd0);
        chk("rst_gnt_b",  32'(gnt_b), 32'd0);
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_cnt",    32'(switch_cnt), 32'd0);
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_out",    32'(out), 32'd0);

        // First tie goes to A, then hold limit alternates every 4 cycles
        reset = 1'b0;
        tick();
        chk("tie0_gnt_a", 32'(gnt_a), 32'd1);
        chk("tie0_gnt_b", 32'(gnt_b), 32'd0);
        chk("tie0_cnt",   32'(switch_cnt), 32'd1);
        for (int k = 1; k < 12; k++) begin
            tick();
            chk("hold_gnt_a", 32'(gnt_a), 32'(((k / 4) % 2) == 0));
            chk("hold_gnt_b", 32'(gnt_b), 32'(((k / 4) % 2) == 1));
            chk("hold_sel",   32'(select), 32'((k / 4) % 2));
            chk("hold_cnt",   32'(switch_cnt), 32'(1 + k / 4));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_out",   32'(out), ((((k - 1) / 4) % 2) == 1) ? 32'h22 : 32'h11);
        end

        // Single requester holds indefinitely
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        reset = 1'b0; req_a = 1'b1; ain = 8'h5A;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("solo_gnt_a", 32'(gnt_a), 32'd1);
            chk("solo_gnt_b", 32'(gnt_b), 32'd0);
            chk("solo_valid", 32'(out_valid), 32'(k >= 1));
            if (k >= 1) chk("solo_out", 32'(out), 32'h5A);
            else        chk("solo_out0", 32'(out), 32'h00);
        end
        chk("solo_cnt", 32'(switch_cnt), 32'd1);

        // Early release with B waiting: direct handover
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        reset = 1'b0; req_a = 1'b1; bin = 8'hC3;
        tick(); tick();
        req_a = 1'b0; req_b = 1'b1;
        tick();
        chk("rel_gnt_b", 32'(gnt_b), 32'd1);
        chk("rel_gnt_a", 32'(gnt_a), 32'd0);
        chk("rel_sel",   32'(select), 32'd1);
        chk("rel_cnt",   32'(switch_cnt), 32'd2);
        chk("rel_valid", 32'(out_valid), 32'd0);
        tick();
        chk("rel_out_b", 32'(out), 32'hC3);
        chk("rel_valid_b", 32'(out_valid), 32'd1);

        // Reset in the middle of OWN_B; next tie goes to A
        reset = 1'b1;
        tick();
        chk("mid_gnt_b", 32'(gnt_b), 32'd0);
        chk("mid_sel",   32'(select), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_cnt",   32'(switch_cnt), 32'd0);
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1;
        tick();
        chk("mid_tie_a", 32'(gnt_a), 32'd1);
        chk("mid_tie_b", 32'(gnt_b), 32'd0);

        // Early release with nobody waiting: IDLE keeps select and out
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        reset = 1'b0; req_a = 1'b1; ain = 8'h3C;
        tick(); tick();
        req_a = 1'b0;
        tick();
        chk("idle_gnt_a", 32'(gnt_a), 32'd0);
        chk("idle_gnt_b", 32'(gnt_b), 32'd0);
        chk("idle_sel",   32'(select), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_out",   32'(out), 32'h3C);
        req_b = 1'b1;
        tick();
        chk("b_gnt_b", 32'(gnt_b), 32'd1);
        req_b = 1'b0;
        tick();
        chk("idle_sel_b", 32'(select), 32'd1);
        chk("idle_gnt_b2", 32'(gnt_b), 32'd0);
        // Last served is B, so tie goes to A; then after A, tie goes to B
        req_a = 1'b1; req_b = 1'b1;
        tick();
        chk("tie_a", 32'(gnt_a), 32'd1);
        req_a = 1'b0; req_b = 1'b0;
        tick();
        req_a = 1'b1; req_b = 1'b1;
        tick();
        chk("tie_b", 32'(gnt_b), 32'd1);
        chk("tie_cnt", 32'(switch_cnt), 32'd4);

        // 256 ownership entries wrap the switch counter
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            req_a = ((i % 2) == 0);
            req_b = ((i % 2) == 1);
            tick();
            if (gnt_a && gnt_b) overlap = 1'b1;
            if (i == 254) chk("wrap_cnt255", 32'(switch_cnt), 32'd255);
        end
        chk("wrap_cnt0",   32'(switch_cnt), 32'd0);
        chk("wrap_gnt_b",  32'(gnt_b), 32'd1);
        chk("wrap_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
